id_branch_predict_ctrl: RTL and testbench

- ID-stage branch/jump control unit with parametrised register width and a parametrised table of saturating counters for branch prediction (pattern history table, PHT).
- Decodes beq/bne/blez/bgtz/bltz/bgez/j/jal/jr/jalr, plus zero-extend selection for andi/ori/xori.
- Conditional branches redirect fetch per prediction in the decode cycle. The registered compare resolves them one cycle later.
- On a mispredict the block issues a recovery redirect and an IF flush, and the counters train.
- Sits between the ID pipeline register, the NPC/PC mux and the IF flush logic.

---
 rtl/id_branch_predict_ctrl.sv | 179 +++++++++++++++++
 tb/tb_id_branch_predict_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_branch_predict_ctrl.sv
// ID-stage branch/jump control with a saturating-counter PHT.
// Predicts in decode and resolves the registered compare one cycle later.
module id_branch_predict_ctrl #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int PHT_DEPTH = 64,
  parameter int CNT_W     = 2,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ir_d,
  input  logic [PC_W-1:0]   pc_d,
  input  logic              valid_d,
  input  logic              stall_d,
  input  logic [DATA_W-1:0] rs_val_d,
  input  logic [DATA_W-1:0] rt_val_d,
  input  logic [PC_W-1:0]   br_target_d,
  output logic [1:0]        pcsel,
  output logic              ext_op,
  output logic              npc_op,
  output logic              flush_f,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mis_cnt
);

  localparam int IDX_W = $clog2(PHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic signed [DATA_W-1:0] ZERO = '0;

  typedef enum logic {IDLE, RESOLVE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               taken_q;
  logic               flush_q;
  logic [PC_W-1:0]    redir_q;
  logic [CNT_W-1:0]   pht_q [PHT_DEPTH];
  logic [STAT_W-1:0]  br_cnt_q;
  logic [STAT_W-1:0]  mis_cnt_q;

  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] fn;
  logic is_beq, is_bne, is_blez, is_bgtz, is_bltz, is_bgez;
  logic is_br, is_jmp, is_jr;
  logic dec_en;
  logic taken_c;
  logic pred;
  logic mispred;
  logic [IDX_W-1:0] idx;
  logic signed [DATA_W-1:0] rs_s;
  logic signed [DATA_W-1:0] rt_s;
  logic unused_ir;

  assign op = ir_d[31:26];
  assign rt = ir_d[20:16];
  assign fn = ir_d[5:0];
  assign unused_ir = ^{ir_d[25:21], ir_d[15:6]};

  assign is_beq  = op == 6'b000100;
  assign is_bne  = op == 6'b000101;
  assign is_blez = op == 6'b000110;
  assign is_bgtz = op == 6'b000111;
  assign is_bltz = (op == 6'b000001) && (rt == 5'b00000);
  assign is_bgez = (op == 6'b000001) && (rt == 5'b00001);
  assign is_br   = is_beq | is_bne | is_blez | is_bgtz | is_bltz | is_bgez;
  assign is_jmp  = (op == 6'b000010) || (op == 6'b000011);
  assign is_jr   = (op == 6'b000000) &&
                   ((fn == 6'b001000) || (fn == 6'b001001));

  assign ext_op = (op == 6'b001100) || (op == 6'b001101) ||
                  (op == 6'b001110);
  assign npc_op = is_jmp;

  // Reset also gates decode so no redirect leaks out while held in reset.
  assign dec_en = valid_d & ~stall_d & ~reset & (state_q == IDLE);

  assign rs_s = rs_val_d;
  assign rt_s = rt_val_d;
  assign idx  = pc_d[IDX_W+1:2];
  assign pred = pht_q[idx][CNT_W-1];
  assign mispred = taken_c ^ pred;

  // Signed branch condition for whichever branch is decoded.
  always_comb begin
    taken_c = 1'b0;
    unique case (1'b1)
      is_beq:  taken_c = rs_s == rt_s;
      is_bne:  taken_c = rs_s != rt_s;
      is_blez: taken_c = rs_s <= ZERO;
      is_bgtz: taken_c = rs_s >  ZERO;
      is_bltz: taken_c = rs_s <  ZERO;
      is_bgez: taken_c = rs_s >= ZERO;
      default: taken_c = 1'b0;
    endcase
  end

  // Next-PC select: resolution owns the cycle after a branch decode.
  always_comb begin
    pcsel = 2'b00;
    if (state_q == RESOLVE) begin
      pcsel = flush_q ? 2'b11 : 2'b00;
    end else if (dec_en) begin
      unique case (1'b1)
        is_jmp:  pcsel = 2'b01;
        is_jr:   pcsel = 2'b10;
        is_br:   pcsel = pred ? 2'b01 : 2'b00;
        default: pcsel = 2'b00;
      endcase
    end
  end

  assign flush_f     = flush_q;
  assign redirect_pc = redir_q;
  assign br_cnt      = br_cnt_q;
  assign mis_cnt     = mis_cnt_q;

  // Branch FSM: capture the outcome in decode, replay it for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      redir_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dec_en && is_br) begin
            state_q <= RESOLVE;
            idx_q   <= idx;
            taken_q <= taken_c;
            flush_q <= mispred;
            if (mispred) begin
              redir_q <= taken_c ? br_target_d : pc_d + PC_W'(8);
            end
          end
        end
        RESOLVE: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Train the PHT entry of the resolving branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CNT_INIT;
    end else if (state_q == RESOLVE) begin
      if (taken_q) begin
        if (pht_q[idx_q] != CNT_MAX)
          pht_q[idx_q] <= pht_q[idx_q] + CNT_W'(1);
      end else begin
        if (pht_q[idx_q] != '0)
          pht_q[idx_q] <= pht_q[idx_q] - CNT_W'(1);
      end
    end
  end

  // Saturating branch and mispredict statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (state_q == RESOLVE) begin
      if (br_cnt_q != STAT_MAX) br_cnt_q <= br_cnt_q + STAT_W'(1);
      if (flush_q && mis_cnt_q != STAT_MAX)
        mis_cnt_q <= mis_cnt_q + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_branch_predict_ctrl.sv
// Bench for id_branch_predict_ctrl.
// Per-cycle model results go through a scoreboard queue.
module tb_id_branch_predict_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        stall_d;
  logic [31:0] rs_val_d;
  logic [31:0] rt_val_d;
  logic [31:0] br_target_d;
  logic [1:0]  pcsel;
  logic        ext_op;
  logic        npc_op;
  logic        flush_f;
  logic [31:0] redirect_pc;
  logic [15:0] br_cnt;
  logic [15:0] mis_cnt;

  id_branch_predict_ctrl #(
    .DATA_W(32), .PC_W(32), .PHT_DEPTH(64), .CNT_W(2), .STAT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .ir_d(ir_d), .pc_d(pc_d),
    .valid_d(valid_d), .stall_d(stall_d),
    .rs_val_d(rs_val_d), .rt_val_d(rt_val_d),
    .br_target_d(br_target_d), .pcsel(pcsel), .ext_op(ext_op),
    .npc_op(npc_op), .flush_f(flush_f), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  pcsel;
    logic        flush;
    logic [31:0] redir;
    logic [15:0] br;
    logic [15:0] mis;
    logic        ext;
    logic        npc;
  } exp_t;

  exp_t sb_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // model state
  bit          m_res;
  bit          m_mis;
  bit          m_taken;
  int          m_idx;
  logic [31:0] m_redir;
  int          m_br;
  int          m_misc;
  int          pht_m[64];

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_RI   = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [31:0] NOP = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op,
                                      input logic [4:0] rt,
                                      input logic [5:0] fn);
    return {op, 5'd3, rt, 10'd0, fn};
  endfunction

  task automatic model_reset();
    m_res = 0; m_mis = 0; m_taken = 0; m_idx = 0;
    m_redir = '0; m_br = 0; m_misc = 0;
    for (int i = 0; i < 64; i++) pht_m[i] = 1;
  endtask

  task automatic step(input logic [31:0] ir, input logic [31:0] pc,
                      input bit v, input bit st,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [31:0] tgt, input bit r);
    exp_t e;
    bit br, jj, jr, tk, pred, den;
    int idx;
    logic [5:0] op;
    op = ir[31:26];
    @(posedge clk);
    #1;
    reset = r; ir_d = ir; pc_d = pc; valid_d = v; stall_d = st;
    rs_val_d = rs; rt_val_d = rt; br_target_d = tgt;
    if (r) model_reset();
    br = 0; tk = 0;
    case (op)
      OP_BEQ:  begin br = 1; tk = (rs == rt); end
      OP_BNE:  begin br = 1; tk = (rs != rt); end
      OP_BLEZ: begin br = 1; tk = ($signed(rs) <= 0); end
      OP_BGTZ: begin br = 1; tk = ($signed(rs) > 0); end
      OP_RI: begin
        if (ir[20:16] == 5'd0) begin br = 1; tk = ($signed(rs) < 0); end
        if (ir[20:16] == 5'd1) begin br = 1; tk = ($signed(rs) >= 0); end
      end
      default: ;
    endcase
    jj = (op == OP_J) || (op == OP_JAL);
    jr = (op == OP_R) && (ir[5:0] == 6'b001000 || ir[5:0] == 6'b001001);
    idx = int'((pc >> 2) & 32'd63);
    pred = pht_m[idx] >= 2;
    den = v && !st && !m_res && !r;
    e.pcsel = 2'b00;
    if (m_res) e.pcsel = m_mis ? 2'b11 : 2'b00;
    else if (den && jj) e.pcsel = 2'b01;
    else if (den && jr) e.pcsel = 2'b10;
    else if (den && br) e.pcsel = pred ? 2'b01 : 2'b00;
    e.flush = m_res && m_mis;
    e.redir = m_redir;
    e.br = 16'(m_br);
    e.mis = 16'(m_misc);
    e.ext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    e.npc = jj;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("pcsel", 32'(pcsel), 32'(e.pcsel));
    chk("flush_f", 32'(flush_f), 32'(e.flush));
    chk("redirect_pc", redirect_pc, e.redir);
    chk("br_cnt", 32'(br_cnt), 32'(e.br));
    chk("mis_cnt", 32'(mis_cnt), 32'(e.mis));
    chk("ext_op", 32'(ext_op), 32'(e.ext));
    chk("npc_op", 32'(npc_op), 32'(e.npc));
    if (!r) begin
      if (m_res) begin
        if (m_taken) begin
          if (pht_m[m_idx] < 3) pht_m[m_idx]++;
        end else begin
          if (pht_m[m_idx] > 0) pht_m[m_idx]--;
        end
        if (m_br < 65535) m_br++;
        if (m_mis && m_misc < 65535) m_misc++;
        m_res = 0;
      end else if (den && br) begin
        m_res = 1; m_idx = idx; m_taken = tk; m_mis = (tk != pred);
        if (m_mis) m_redir = tk ? tgt : pc + 32'd8;
      end
    end
  endtask

  task automatic idle(input logic [31:0] pc);
    step(NOP, pc, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic br_pass(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] tgt);
    step(ir, pc, 1, 0, rs, rt, tgt, 0);
    idle(pc + 4);
    idle(pc + 8);
  endtask

  initial begin
    int b0;
    logic [31:0] ir_r;
    logic [5:0] ops[8];
    reset = 1; ir_d = '0; pc_d = '0; valid_d = 0; stall_d = 0;
    rs_val_d = '0; rt_val_d = '0; br_target_d = '0;
    model_reset();
    step(NOP, 0, 0, 0, 0, 0, 0, 1);
    step(NOP, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_pcsel", 32'(pcsel), 0);
    chk("rst_redir", redirect_pc, 0);

    // first beq: weakly not-taken, actually taken
    step(enc(OP_BEQ, 5'd4, 0), 32'h100, 1, 0, 5, 5, 32'h200, 0);
    chk("beq1_c0_pcsel", 32'(pcsel), 0);
    idle(32'h104);
    chk("beq1_c1_pcsel", 32'(pcsel), 3);
    chk("beq1_c1_flush", 32'(flush_f), 1);
    chk("beq1_c1_redir", redirect_pc, 32'h200);
    idle(32'h108);
    chk("beq1_pht", 32'(dut.pht_q[0]), 2);
    chk("beq1_br", 32'(br_cnt), 1);
    chk("beq1_mis", 32'(mis_cnt), 1);

    step(enc(OP_BEQ, 5'd4, 0), 32'h100, 1, 0, 5, 5, 32'h200, 0);
    chk("beq2_c0_pcsel", 32'(pcsel), 1);
    idle(32'h104);
    chk("beq2_c1_pcsel", 32'(pcsel), 0);
    chk("beq2_c1_flush", 32'(flush_f), 0);
    idle(32'h108);
    br_pass(enc(OP_BEQ, 5'd4, 0), 32'h100, 5, 5, 32'h200);
    chk("beq3_pht", 32'(dut.pht_q[0]), 3);
    br_pass(enc(OP_BEQ, 5'd4, 0), 32'h100, 5, 5, 32'h200);
    chk("beq4_pht", 32'(dut.pht_q[0]), 3);

    // bne on strongly-taken entry, not taken
    step(enc(OP_BNE, 5'd4, 0), 32'h100, 1, 0, 7, 7, 32'h300, 0);
    chk("bne_c0_pcsel", 32'(pcsel), 1);
    idle(32'h104);
    chk("bne_c1_pcsel", 32'(pcsel), 3);
    chk("bne_c1_redir", redirect_pc, 32'h108);
    idle(32'h108);
    chk("bne_pht", 32'(dut.pht_q[0]), 2);

    // signed boundaries
    br_pass(enc(OP_RI, 5'd0, 0), 32'h204, 32'h8000_0000, 0, 32'h280);
    chk("bltz_pht", 32'(dut.pht_q[1]), 2);
    br_pass(enc(OP_RI, 5'd1, 0), 32'h208, 0, 0, 32'h280);
    chk("bgez_pht", 32'(dut.pht_q[2]), 2);
    br_pass(enc(OP_BLEZ, 5'd0, 0), 32'h20c, 1, 0, 32'h280);
    chk("blez_pht", 32'(dut.pht_q[3]), 0);
    br_pass(enc(OP_BGTZ, 5'd0, 0), 32'h210, 0, 0, 32'h280);
    chk("bgtz_pht", 32'(dut.pht_q[4]), 0);
    b0 = m_br;
    step(enc(OP_RI, 5'd2, 0), 32'h214, 1, 0, 32'h8000_0000, 0, 32'h280, 0);
    chk("ri2_pcsel", 32'(pcsel), 0);
    idle(32'h218);
    idle(32'h21c);
    chk("ri2_nores", 32'(br_cnt), 32'(b0));

    // jumps and extension select
    step(enc(OP_J, 0, 0), 32'h220, 1, 0, 0, 0, 0, 0);
    chk("j_pcsel", 32'(pcsel), 1);
    chk("j_npc", 32'(npc_op), 1);
    step(enc(OP_R, 0, 6'b001000), 32'h224, 1, 0, 0, 0, 0, 0);
    chk("jr_pcsel", 32'(pcsel), 2);
    step(enc(OP_ORI, 0, 0), 32'h228, 1, 0, 0, 0, 0, 0);
    chk("ori_ext", 32'(ext_op), 1);
    step(enc(OP_ADDI, 0, 0), 32'h22c, 1, 0, 0, 0, 0, 0);
    chk("addi_ext", 32'(ext_op), 0);
    step(enc(OP_J, 0, 0), 32'h230, 1, 1, 0, 0, 0, 0);
    chk("j_stall_pcsel", 32'(pcsel), 0);
    step(enc(OP_J, 0, 0), 32'h230, 0, 0, 0, 0, 0, 0);
    chk("j_invalid_pcsel", 32'(pcsel), 0);

    // branch in the delay slot is ignored
    b0 = m_br;
    step(enc(OP_BEQ, 5'd4, 0), 32'h500, 1, 0, 1, 2, 32'h600, 0);
    step(enc(OP_BEQ, 5'd4, 0), 32'h504, 1, 0, 3, 3, 32'h700, 0);
    idle(32'h508);
    idle(32'h50c);
    chk("ds_br_once", 32'(br_cnt), 32'(b0 + 1));

    // reset while a mispredict is resolving
    step(enc(OP_BEQ, 5'd4, 0), 32'h3f0, 1, 0, 1, 1, 32'h400, 0);
    step(NOP, 32'h3f4, 1, 0, 0, 0, 0, 1);
    chk("rstres_pcsel", 32'(pcsel), 0);
    chk("rstres_flush", 32'(flush_f), 0);
    idle(32'h3f8);
    chk("rstres_pht60", 32'(dut.pht_q[60]), 1);
    chk("rstres_pht0", 32'(dut.pht_q[0]), 1);
    chk("rstres_br", 32'(br_cnt), 0);

    // random mix
    ops[0] = OP_BEQ; ops[1] = OP_BNE; ops[2] = OP_BLEZ; ops[3] = OP_BGTZ;
    ops[4] = OP_RI;  ops[5] = OP_J;   ops[6] = OP_R;    ops[7] = OP_XORI;
    for (int i = 0; i < 200; i++) begin
      logic [5:0] o;
      o = ops[$urandom_range(0, 7)];
      ir_r = enc(o, 5'($urandom_range(0, 2)),
                 ($urandom_range(0, 1) != 0) ? 6'b001000 : 6'b000000);
      step(ir_r, {24'h0, 4'($urandom_range(0, 15)), 4'h0}, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) - 1,
           $urandom_range(0, 2) - 1, $urandom, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
